// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES-256 constants and GF(2^8) helpers for the cipher pipeline.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int NR               = 14;
    localparam int LATENCY          = 121;
    localparam int STAGES_PER_ROUND = 8;
    localparam int BALANCE          = 6;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input int i);
        case (i)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    // Column bytes are {a0,a1,a2,a3} from MSB; 3*a is expressed as xtime(a)^a.
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3, x0, x1, x2, x3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        x0 = xtime(a0); x1 = xtime(a1); x2 = xtime(a2); x3 = xtime(a3);
        return {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                a0 ^ x1 ^ x2 ^ a2 ^ a3,
                a0 ^ a1 ^ x2 ^ x3 ^ a3,
                x0 ^ a0 ^ a1 ^ a2 ^ x3};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round.sv
// ============================================================================
// Module : aes_round
// Brief  : One 8-stage AES round with its companion key-expansion step.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aes_round
    import aes_pkg::*;
#(
    parameter int ROUND  = 1,
    parameter bit DO_MIX = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] i_state,
    input  logic [255:0] i_key,
    output logic [127:0] o_state,
    output logic [255:0] o_key
);

    localparam int DELAY = STAGES_PER_ROUND - 3;

    logic [127:0] w_sb;
    logic [127:0] w_mc;
    logic [31:0]  w_t;
    logic [127:0] w_new;
    logic [255:0] w_kx;

    logic [127:0] r_sb;
    logic [127:0] r_mc;
    logic [127:0] r_ark;
    logic [255:0] r_k1;
    logic [255:0] r_k2;
    logic [255:0] r_k3;
    logic [127:0] r_dly  [DELAY];
    logic [255:0] r_kdly [DELAY];

    // SubBytes and ShiftRows commute, so both are folded into one gather.
    always_comb begin
        w_sb = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sb[127-8*(r+4*c) -: 8] = sbox(i_state[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
    end

    always_comb begin
        w_mc = r_sb;
        if (DO_MIX) begin
            for (int c = 0; c < 4; c++) begin
                w_mc[127-32*c -: 32] = mix_column(r_sb[127-32*c -: 32]);
            end
        end
    end

    // Key window {rk[ROUND-1], rk[ROUND]} advances to {rk[ROUND], rk[ROUND+1]}.
    always_comb begin
        w_t   = '0;
        w_new = '0;
        if (ROUND < NR) begin
            if (ROUND % 2 == 1) begin
                w_t = sub_word({r_k1[23:0], r_k1[31:24]}) ^ {rcon((ROUND + 1) / 2), 24'h0};
            end else begin
                w_t = sub_word(r_k1[31:0]);
            end
            w_new[127:96] = r_k1[255:224] ^ w_t;
            w_new[95:64]  = r_k1[223:192] ^ w_new[127:96];
            w_new[63:32]  = r_k1[191:160] ^ w_new[95:64];
            w_new[31:0]   = r_k1[159:128] ^ w_new[63:32];
        end
    end

    assign w_kx = {r_k1[127:0], w_new};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb  <= '0;
            r_mc  <= '0;
            r_ark <= '0;
            r_k1  <= '0;
            r_k2  <= '0;
            r_k3  <= '0;
            for (int i = 0; i < DELAY; i++) begin
                r_dly[i]  <= '0;
                r_kdly[i] <= '0;
            end
        end else begin
            r_sb  <= w_sb;
            r_k1  <= i_key;
            r_mc  <= w_mc;
            r_k2  <= w_kx;
            r_ark <= r_mc ^ r_k2[255:128];
            r_k3  <= r_k2;
            r_dly[0]  <= r_ark;
            r_kdly[0] <= r_k3;
            for (int i = 1; i < DELAY; i++) begin
                r_dly[i]  <= r_dly[i-1];
                r_kdly[i] <= r_kdly[i-1];
            end
        end
    end

    assign o_state = r_dly[DELAY-1];
    assign o_key   = r_kdly[DELAY-1];

endmodule

`default_nettype wire

// File: rtl/aes_256_top.sv
// ============================================================================
// Module : aes_256_top
// Brief  : Fully pipelined AES-256 encryptor, one block per cycle, 121-cycle latency.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aes_256_top
    import aes_pkg::*;
(
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [127:0] STATE,
    input  logic [255:0] KEY,
    output logic [127:0] OUT
);

    logic [127:0] r_in_state;
    logic [255:0] r_in_key;
    logic [127:0] r_ark0;
    logic [255:0] r_key0;
    logic [127:0] r_bal   [BALANCE];
    logic [LATENCY-2:0] r_valid;

    logic [127:0] w_state [0:NR];
    logic [255:0] w_key   [0:NR];

    assign w_state[0] = r_ark0;
    assign w_key[0]   = r_key0;

    for (genvar r = 1; r <= NR; r++) begin : g_round
        aes_round #(
            .ROUND  (r),
            .DO_MIX (r != NR)
        ) u_round (
            .clk     (CLK),
            .rst_n   (RST_N),
            .i_state (w_state[r-1]),
            .i_key   (w_key[r-1]),
            .o_state (w_state[r]),
            .o_key   (w_key[r])
        );
    end

    // OUT itself is the last valid stage, so the gate looks one stage earlier.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_in_state <= '0;
            r_in_key   <= '0;
            r_ark0     <= '0;
            r_key0     <= '0;
            r_valid    <= '0;
            OUT        <= '0;
            for (int i = 0; i < BALANCE; i++) begin
                r_bal[i] <= '0;
            end
        end else begin
            r_in_state <= STATE;
            r_in_key   <= KEY;
            r_ark0     <= r_in_state ^ r_in_key[255:128];
            r_key0     <= r_in_key;
            r_valid    <= {r_valid[LATENCY-3:0], 1'b1};
            r_bal[0]   <= w_state[NR];
            for (int i = 1; i < BALANCE; i++) begin
                r_bal[i] <= r_bal[i-1];
            end
            OUT <= r_valid[LATENCY-2] ? r_bal[BALANCE-1] : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_256_top.sv
// ============================================================================
// Module : tb_aes_256_top
// Brief  : Directed-vector and reference-model checks for aes_256_top.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_aes_256_top;

    localparam int LAT = 121;

    localparam logic [255:0] V1_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V1_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] V2_KEY = 256'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe;
    localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V2_CT  = 128'h1a6e6c2c662e7da6501ffb62bc9e93f3;
    localparam logic [255:0] V3_KEY = 256'hee445732e5e9bc9bf508cf25535ee2e9b2d2aa6054fa85d0d4e835d898648266;
    localparam logic [127:0] V3_PT  = 128'h7e4c7e6a48b32551943a5384909931fb;
    localparam logic [127:0] V3_CT  = 128'h6ac83d115d0102158a6de49df3cf5de0;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [127:0] STATE;
    logic [255:0] KEY;
    logic [127:0] OUT;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0]   sb   [256];
    logic [127:0] hist [LAT];

    aes_256_top dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .STATE (STATE),
        .KEY   (KEY),
        .OUT   (OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box derived from first principles: GF(2^8) inverse plus affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [255:0] key, input logic [127:0] pt);
        logic [31:0]  w   [60];
        logic [7:0]   st  [16];
        logic [7:0]   tmp [16];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 16; k++) st[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int k = 0; k < 16; k++) tmp[k] = sb[st[(k%4) + 4*(((k/4) + (k%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 14) begin
                    st[4*c]   = gmul(tmp[4*c], 8'h02) ^ gmul(tmp[4*c+1], 8'h03) ^ tmp[4*c+2] ^ tmp[4*c+3];
                    st[4*c+1] = tmp[4*c] ^ gmul(tmp[4*c+1], 8'h02) ^ gmul(tmp[4*c+2], 8'h03) ^ tmp[4*c+3];
                    st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ gmul(tmp[4*c+2], 8'h02) ^ gmul(tmp[4*c+3], 8'h03);
                    st[4*c+3] = gmul(tmp[4*c], 8'h03) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ gmul(tmp[4*c+3], 8'h02);
                end else begin
                    for (int i = 0; i < 4; i++) st[4*c+i] = tmp[4*c+i];
                end
            end
            for (int k = 0; k < 16; k++) st[k] = st[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = st[k];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd128(), rnd128()};
    endfunction

    task automatic clear_hist();
        for (int i = 0; i < LAT; i++) hist[i] = '0;
    endtask

    // One clock: present inputs, take the edge, then compare OUT with the
    // block sampled LAT-1 edges earlier (zero while nothing valid is in flight).
    task automatic tick(input logic [127:0] s, input logic [255:0] k, input logic [127:0] e);
        STATE = s;
        KEY   = k;
        @(posedge CLK);
        for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = RST_N ? e : '0;
        cyc++;
        #1;
        chk($sformatf("pipe@%0d", cyc), OUT, hist[LAT-1]);
    endtask

    task automatic tick_rnd();
        logic [127:0] s;
        logic [255:0] k;
        s = rnd128();
        k = rnd256();
        tick(s, k, aes_ref(k, s));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        build_sbox();
        clear_hist();
        RST_N = 1'b0;
        STATE = '0;
        KEY   = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_out", OUT, '0);

        // Release, then vector 1 at the first edge: 120 zero edges then the ciphertext.
        RST_N = 1'b1;
        tick(V1_PT, V1_KEY, V1_CT);
        repeat (119) tick(128'h0, 256'h0, aes_ref(256'h0, 128'h0));
        chk("fill_zero_e120", OUT, '0);
        tick(128'h0, 256'h0, aes_ref(256'h0, 128'h0));
        chk("v1_at_121", OUT, V1_CT);

        // Back-to-back vectors 2, 1, 3 with differing keys.
        tick(V2_PT, V2_KEY, V2_CT);
        tick(V1_PT, V1_KEY, V1_CT);
        tick(V3_PT, V3_KEY, V3_CT);
        repeat (118) tick_rnd();
        chk("stream_v2", OUT, V2_CT);
        tick_rnd();
        chk("stream_v1", OUT, V1_CT);
        tick_rnd();
        chk("stream_v3", OUT, V3_CT);

        // Mid-stream reset between edges discards everything in flight.
        repeat (50) tick_rnd();
        RST_N = 1'b0;
        #2;
        chk("midrst_now", OUT, '0);
        clear_hist();
        repeat (3) tick_rnd();
        RST_N = 1'b1;
        tick(V2_PT, V2_KEY, V2_CT);
        repeat (119) tick_rnd();
        chk("midrst_fill_zero", OUT, '0);
        tick_rnd();
        chk("midrst_v2", OUT, V2_CT);

        // Soak: random key/plaintext every cycle, then drain.
        repeat (500) tick_rnd();
        repeat (LAT) tick_rnd();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_256_top.md
Name: aes_256_top

Overview:
Fully pipelined AES-256 encryption engine (FIPS-197 cipher, 14 rounds) that accepts one 128-bit plaintext block and one 256-bit key every clock cycle. Each ciphertext appears on OUT exactly 121 cycles after its inputs are presented. Key expansion is pipelined alongside the data path, so every block may use a different key. It sits as the top-level crypto datapath; it has no handshake, and throughput is one block per cycle.

Parameters:
LATENCY, 121, number of register stages from STATE/KEY sampling to OUT (fixed; the bench depends on it).

Ports:
CLK    input   1    rising-edge clock
RST_N  input   1    asynchronous active-low reset
STATE  input   128  plaintext block; bit 127 = first byte of FIPS-197 input
KEY    input   256  cipher key; bit 255 = first key byte
OUT    output  128  ciphertext; bit 127 = first output byte

Behaviour:
- One clock, CLK. RST_N is asynchronous active-low: assertion immediately clears every pipeline register, valid bit and OUT to 0; release is synchronous to CLK.
- STATE and KEY are sampled at every rising edge E. AES256(KEY, STATE) is driven on OUT after rising edge E+120 and held until edge E+121. That is 121 register stages, counting the input register as stage 1.
- Back-to-back blocks are supported with no bubbles. Each block is independent and uses its own key; there is no chaining between blocks.
- Stage budget:
  - input register: 1
  - initial AddRoundKey: 1
  - 14 rounds × 8 stages: 112. Round 14 omits MixColumns and is padded to 8 stages.
  - output register: 1
  - balance delay: 6
  - total: 121
- Round-key generation runs in a parallel pipeline aligned with the data. Round key r must be available at the AddRoundKey stage of round r, for the same block.
- Valid chain: a 1-bit shift register of length LATENCY.
  - Input is 1 in every cycle while RST_N is high.
  - OUT loads pipeline data only when the chain output is 1; otherwise OUT holds 0.
  - After reset release, OUT = 0 for the first 120 edges. The block sampled at the first edge after release appears after edge 121.
- Reset mid-operation: all in-flight blocks are discarded, OUT = 0 at once, and the 121-cycle fill restarts.
- Arithmetic:
  - S-box: standard AES S-box, implemented as a lookup table or a composite-field equivalent.
  - xtime: GF(2^8) multiply by 2 modulo 0x11B.
  - Rcon sequence: 01, 02, 04, 08, 10, 20, 40.
  - AES-256 key schedule: SubWord without rotation on every 4th word of each 8-word group (i mod 8 == 4).
- No X propagation: every register has a reset value of 0.

Decomposition:
- Package aes_pkg: S-box table or function, xtime function, Rcon constants, NR = 14, LATENCY = 121.
- Sub-module aes_round: one pipelined round (SubBytes, ShiftRows, MixColumns bypassable by a parameter for the final round, AddRoundKey). The matching key-expansion step is either a companion sub-module or part of aes_round.
- Top: instantiates 14 aes_round instances, the key pipeline, the valid chain and the balance delay.

Test Plan:
1. FIPS-197 C.3: KEY = 000102…1e1f, STATE = 00112233445566778899aabbccddeeff → OUT = 8ea2b7ca516745bfeafc49904b496089 exactly 121 cycles later.
2. KEY = 2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe, STATE = 3243f6a8885a308d313198a2e0370734 → OUT = 1a6e6c2c662e7da6501ffb62bc9e93f3.
3. Back-to-back streaming: drive vector 2, then vector 1, then KEY = ee445732e5e9bc9bf508cf25535ee2e9b2d2aa6054fa85d0d4e835d898648266 with STATE = 7e4c7e6a48b32551943a5384909931fb, on consecutive cycles → OUT shows 1a6e…93f3, 8ea2…6089, 6ac83d115d0102158a6de49df3cf5de0 on consecutive cycles starting at latency 121.
4. Reset and fill: assert RST_N = 0, release, drive vector 1 at the first edge → OUT = 0 for 120 edges, then 8ea2b7ca… after edge 121.
5. Mid-stream reset: stream 50 random blocks, pulse RST_N low between edges → OUT drops to 0 immediately and none of the pre-reset blocks ever appear.
6. Soak: 500 random key/plaintext pairs, one per cycle → OUT matches a reference model with zero mismatches and no gaps.
